// File: rtl/mips_fetch_ctrl_if.sv
// mips_fetch_ctrl_if: bus bundle between the fetch controller and the
// PC register, instruction memory, hazard and branch logic.
//   master : fetch controller (drives PCWrite/PCin, IMEM_REQ, pipe ctrl,
//            STALL_CNT; receives PCout, IMEM_READY, hazard/redirect info)
//   slave  : surrounding pipeline (opposite directions)
interface mips_fetch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      PCout;
    logic             IMEM_READY;
    logic [4:0]       IF_ID_Rs;
    logic [4:0]       IF_ID_Rt;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_Rt;
    logic             JumpID;
    logic [31:0]      JumpTarget;
    logic             BranchEX;
    logic [31:0]      BranchTarget;

    logic             PCWrite;
    logic [31:0]      PCin;
    logic             IMEM_REQ;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic [CNT_W-1:0] STALL_CNT;

    modport master (
        input  PCout,
        input  IMEM_READY,
        input  IF_ID_Rs,
        input  IF_ID_Rt,
        input  ID_EX_MemRead,
        input  ID_EX_Rt,
        input  JumpID,
        input  JumpTarget,
        input  BranchEX,
        input  BranchTarget,
        output PCWrite,
        output PCin,
        output IMEM_REQ,
        output IF_ID_Write,
        output IF_ID_Flush,
        output ID_EX_Flush,
        output STALL_CNT
    );

    modport slave (
        output PCout,
        output IMEM_READY,
        output IF_ID_Rs,
        output IF_ID_Rt,
        output ID_EX_MemRead,
        output ID_EX_Rt,
        output JumpID,
        output JumpTarget,
        output BranchEX,
        output BranchTarget,
        input  PCWrite,
        input  PCin,
        input  IMEM_REQ,
        input  IF_ID_Write,
        input  IF_ID_Flush,
        input  ID_EX_Flush,
        input  STALL_CNT
    );
endinterface

// File: rtl/mips_fetch_ctrl.sv
// mips_fetch_ctrl: fetch-stage controller. Sequences boot, sequential
// fetch, load-use stalls, jump/branch redirects and imem waits.
// Ports: CLK, RESET (async active-low), bus (mips_fetch_ctrl_if.master)
//   carrying PCout/IMEM_READY/hazard/redirect inputs and PCWrite/PCin,
//   IMEM_REQ, IF/ID + ID/EX controls and the saturating STALL_CNT.
module mips_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    mips_fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        lu;
    logic [31:0] pc_seq;
    logic        pc_write;
    logic [31:0] pc_in;
    logic        imem_req;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;

    assign pc_seq = bus.PCout + 32'd4;

    // $zero is never a real dependency, so a load into r0 cannot stall
    assign lu = bus.ID_EX_MemRead
              && (bus.ID_EX_Rt != 5'd0)
              && ((bus.ID_EX_Rt == bus.IF_ID_Rs)
               || (bus.ID_EX_Rt == bus.IF_ID_Rt));

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        imem_req    = 1'b1;
        if_id_write = 1'b1;
        pc_write    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_in       = pc_seq;
        unique case (state_q)
            BOOT: begin
                imem_req    = 1'b0;
                if_id_write = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                pc_write    = 1'b1;
                pc_in       = RESET_PC;
                state_d     = RUN;
            end
            RUN: begin
                if (bus.BranchEX) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (bus.IMEM_READY) begin
                        pc_write = 1'b1;
                        pc_in    = bus.BranchTarget;
                    end else begin
                        pend_d  = bus.BranchTarget;
                        state_d = HOLD;
                    end
                end else if (lu) begin
                    // a concurrent jump stays in ID and retries next cycle
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (bus.JumpID) begin
                    if_id_flush = 1'b1;
                    if (bus.IMEM_READY) begin
                        pc_write = 1'b1;
                        pc_in    = bus.JumpTarget;
                    end else begin
                        pend_d  = bus.JumpTarget;
                        state_d = HOLD;
                    end
                end else if (bus.IMEM_READY) begin
                    pc_write = 1'b1;
                end else begin
                    if_id_flush = 1'b1;
                end
            end
            HOLD: begin
                // wrong-path fetch still in flight; only a newer
                // branch may replace the pending target
                if_id_flush = 1'b1;
                pc_in       = pend_q;
                if (bus.BranchEX) begin
                    pend_d      = bus.BranchTarget;
                    id_ex_flush = 1'b1;
                end
                if (bus.IMEM_READY) begin
                    pc_write = 1'b1;
                    pc_in    = bus.BranchEX ? bus.BranchTarget : pend_q;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != BOOT) && !pc_write
            && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= BOOT;
            pend_q  <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCin        = pc_in;
    assign bus.IMEM_REQ    = imem_req;
    assign bus.IF_ID_Write = if_id_write;
    assign bus.IF_ID_Flush = if_id_flush;
    assign bus.ID_EX_Flush = id_ex_flush;
    assign bus.STALL_CNT   = cnt_q;

endmodule

// File: tb/tb_mips_fetch_ctrl.sv
// tb_mips_fetch_ctrl: directed bench for mips_fetch_ctrl with a
// behavioural reference model checked every cycle.
module tb_mips_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          CW     = 4;
    localparam int          CMAX   = (1 << CW) - 1;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] pc_q   = 32'h0;
    logic        frc_en = 1'b0;
    logic [31:0] frc_val = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    mips_fetch_ctrl_if #(.CNT_W(CW)) bus ();

    mips_fetch_ctrl #(
        .RESET_PC(RST_PC),
        .CNT_W   (CW)
    ) dut (
        .CLK  (clk),
        .RESET(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // PC register stand-in; the bench can override what the DUT sees
    always @(posedge clk) begin
        if (bus.PCWrite) pc_q <= bus.PCin;
    end
    assign bus.PCout = frc_en ? frc_val : pc_q;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = just reset, 1 = fetching, 2 = waiting out a wrong-path fetch
    int          m_mode = 0;
    logic [31:0] m_pend = RST_PC;
    int          m_cnt  = 0;
    int          nx_mode;
    logic [31:0] nx_pend;
    logic        e_pcw;

    always @(negedge rst_n) begin
        m_mode = 0;
        m_pend = RST_PC;
        m_cnt  = 0;
    end

    always @(negedge clk) begin
        logic        e_req, e_wr, e_iff, e_idf;
        logic [31:0] e_pcin;
        logic        hz;
        e_req = 1; e_wr = 1; e_iff = 0; e_idf = 0; e_pcw = 0;
        e_pcin = bus.PCout + 32'd4;
        nx_mode = m_mode;
        nx_pend = m_pend;
        hz = bus.ID_EX_MemRead && bus.ID_EX_Rt != 0
             && (bus.ID_EX_Rt == bus.IF_ID_Rs || bus.ID_EX_Rt == bus.IF_ID_Rt);
        if (m_mode == 0) begin
            e_req = 0; e_wr = 0; e_iff = 1; e_idf = 1;
            e_pcw = 1; e_pcin = RST_PC; nx_mode = 1;
        end else if (m_mode == 2) begin
            e_iff = 1;
            e_idf = bus.BranchEX;
            if (bus.BranchEX) nx_pend = bus.BranchTarget;
            e_pcin = (bus.IMEM_READY && bus.BranchEX) ? bus.BranchTarget : m_pend;
            if (bus.IMEM_READY) begin
                e_pcw = 1; nx_mode = 1;
            end
        end else begin
            logic        redir;
            logic [31:0] tgt;
            redir = 0; tgt = 0;
            if (bus.BranchEX) begin
                redir = 1; tgt = bus.BranchTarget; e_idf = 1;
            end else if (hz) begin
                e_wr = 0; e_idf = 1;
            end else if (bus.JumpID) begin
                redir = 1; tgt = bus.JumpTarget;
            end
            if (redir) begin
                e_iff = 1;
                if (bus.IMEM_READY) begin
                    e_pcw = 1; e_pcin = tgt;
                end else begin
                    nx_mode = 2; nx_pend = tgt;
                end
            end else if (!hz) begin
                e_pcw = bus.IMEM_READY;
                e_iff = !bus.IMEM_READY;
            end
        end
        chk("m_PCWrite", {31'b0, bus.PCWrite}, {31'b0, e_pcw});
        chk("m_PCin", bus.PCin, e_pcin);
        chk("m_IMEM_REQ", {31'b0, bus.IMEM_REQ}, {31'b0, e_req});
        chk("m_IF_ID_Write", {31'b0, bus.IF_ID_Write}, {31'b0, e_wr});
        chk("m_IF_ID_Flush", {31'b0, bus.IF_ID_Flush}, {31'b0, e_iff});
        chk("m_ID_EX_Flush", {31'b0, bus.ID_EX_Flush}, {31'b0, e_idf});
        chk("m_STALL_CNT", 32'(bus.STALL_CNT), 32'(m_cnt));
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_mode != 0 && !e_pcw && m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_mode = nx_mode;
            m_pend = nx_pend;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.IF_ID_Rs      = 0;
        bus.IF_ID_Rt      = 0;
        bus.ID_EX_MemRead = 0;
        bus.ID_EX_Rt      = 0;
        bus.JumpID        = 0;
        bus.JumpTarget    = 0;
        bus.BranchEX      = 0;
        bus.BranchTarget  = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();
    endtask

    initial begin
        clr();
        bus.IMEM_READY = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, bus.IMEM_REQ}, 32'd0);
        chk("rst_pcw", {31'b0, bus.PCWrite}, 32'd1);
        chk("rst_pcin", bus.PCin, 32'h100);
        chk("rst_cnt", 32'(bus.STALL_CNT), 32'd0);
        rst_n = 1;
        #2;
        chk("boot_pcin", bus.PCin, 32'h100);
        chk("boot_iff", {31'b0, bus.IF_ID_Flush}, 32'd1);
        step(); #2;
        chk("seq1_pcin", bus.PCin, 32'h104);
        chk("seq1_pcw", {31'b0, bus.PCWrite}, 32'd1);
        step(); #2;
        chk("seq2_pcin", bus.PCin, 32'h108);
        chk("seq2_cnt", 32'(bus.STALL_CNT), 32'd0);

        // load-use
        step();
        bus.ID_EX_MemRead = 1; bus.ID_EX_Rt = 5; bus.IF_ID_Rs = 5;
        #2;
        chk("lu_pcw", {31'b0, bus.PCWrite}, 32'd0);
        chk("lu_wr", {31'b0, bus.IF_ID_Write}, 32'd0);
        chk("lu_idf", {31'b0, bus.ID_EX_Flush}, 32'd1);
        step(); clr(); #2;
        chk("lu_cnt", 32'(bus.STALL_CNT), 32'd1);

        // load-use beats jump, jump retried next cycle
        step();
        bus.ID_EX_MemRead = 1; bus.ID_EX_Rt = 7; bus.IF_ID_Rt = 7;
        bus.JumpID = 1; bus.JumpTarget = 32'h800;
        #2;
        chk("luj_pcw", {31'b0, bus.PCWrite}, 32'd0);
        chk("luj_iff", {31'b0, bus.IF_ID_Flush}, 32'd0);
        step();
        bus.ID_EX_MemRead = 0; bus.ID_EX_Rt = 0; bus.IF_ID_Rt = 0;
        #2;
        chk("jmp_pcin", bus.PCin, 32'h800);
        chk("jmp_iff", {31'b0, bus.IF_ID_Flush}, 32'd1);
        step(); clr();

        // load into r0 never stalls
        bus.ID_EX_MemRead = 1;
        #2;
        chk("r0_pcw", {31'b0, bus.PCWrite}, 32'd1);
        chk("r0_pcin", bus.PCin, 32'h804);
        step(); clr(); #2;
        chk("r0_cnt", 32'(bus.STALL_CNT), 32'd2);

        // branch beats jump
        step();
        bus.BranchEX = 1; bus.BranchTarget = 32'h400;
        bus.JumpID = 1; bus.JumpTarget = 32'h800;
        #2;
        chk("bj_pcin", bus.PCin, 32'h400);
        chk("bj_iff", {31'b0, bus.IF_ID_Flush}, 32'd1);
        chk("bj_idf", {31'b0, bus.ID_EX_Flush}, 32'd1);
        step(); clr(); #2;
        chk("bj_next", bus.PCin, 32'h404);

        // jump during imem wait
        do_reset();
        frc_en = 1; frc_val = 32'h20;
        bus.IMEM_READY = 0; bus.JumpID = 1; bus.JumpTarget = 32'h200;
        #2;
        chk("jw_pcw", {31'b0, bus.PCWrite}, 32'd0);
        chk("jw_pcin", bus.PCin, 32'h24);
        step(); bus.JumpID = 0; #2;
        chk("hold_pcin", bus.PCin, 32'h200);
        chk("hold_iff", {31'b0, bus.IF_ID_Flush}, 32'd1);
        step();
        step(); bus.IMEM_READY = 1; #2;
        chk("hold_rel_pcw", {31'b0, bus.PCWrite}, 32'd1);
        chk("hold_rel_pcin", bus.PCin, 32'h200);
        step(); frc_en = 0; #2;
        chk("jw_cnt", 32'(bus.STALL_CNT), 32'd3);
        chk("jw_run", bus.PCin, 32'h204);

        // branch replaces pending target in HOLD
        step();
        bus.IMEM_READY = 0; bus.BranchEX = 1; bus.BranchTarget = 32'h600;
        step(); bus.BranchTarget = 32'h700; #2;
        chk("hb_idf", {31'b0, bus.ID_EX_Flush}, 32'd1);
        chk("hb_pcin", bus.PCin, 32'h600);
        step(); clr(); bus.IMEM_READY = 1; #2;
        chk("hb_rel", bus.PCin, 32'h700);
        step(); #2;
        chk("hb_next", bus.PCin, 32'h704);
        chk("hb_cnt", 32'(bus.STALL_CNT), 32'd5);

        // branch and ready together in HOLD; jump ignored
        step();
        bus.IMEM_READY = 0; bus.JumpID = 1; bus.JumpTarget = 32'h900;
        step();
        bus.IMEM_READY = 1; bus.BranchEX = 1; bus.BranchTarget = 32'hA00;
        bus.JumpTarget = 32'hB00;
        #2;
        chk("hbr_pcin", bus.PCin, 32'hA00);
        chk("hbr_pcw", {31'b0, bus.PCWrite}, 32'd1);
        step(); clr();

        // wrap
        frc_en = 1; frc_val = 32'hFFFF_FFFC;
        #2;
        chk("wrap_pcin", bus.PCin, 32'h0);
        step(); frc_en = 0;

        // saturation
        do_reset();
        bus.IMEM_READY = 0;
        repeat (20) step();
        #2;
        chk("sat_cnt", 32'(bus.STALL_CNT), 32'd15);

        // reset in HOLD
        bus.IMEM_READY = 0; bus.JumpID = 1; bus.JumpTarget = 32'h300;
        step(); bus.JumpID = 0; #2;
        chk("rh_hold", bus.PCin, 32'h300);
        #1;
        rst_n = 0;
        #1;
        chk("rh_req", {31'b0, bus.IMEM_REQ}, 32'd0);
        chk("rh_pcw", {31'b0, bus.PCWrite}, 32'd1);
        chk("rh_pcin", bus.PCin, 32'h100);
        chk("rh_cnt", 32'(bus.STALL_CNT), 32'd0);
        step(); step();
        rst_n = 1; bus.IMEM_READY = 1;
        step(); #2;
        chk("rh_after", bus.PCin, 32'h104);

        // mixed directed/random traffic, checked by the model
        for (int i = 0; i < 300; i++) begin
            step();
            bus.IMEM_READY    = ($urandom_range(0, 3) != 0);
            bus.ID_EX_MemRead = ($urandom_range(0, 2) == 0);
            bus.ID_EX_Rt      = 5'($urandom_range(0, 3));
            bus.IF_ID_Rs      = 5'($urandom_range(0, 3));
            bus.IF_ID_Rt      = 5'($urandom_range(0, 3));
            bus.JumpID        = ($urandom_range(0, 4) == 0);
            bus.JumpTarget    = $urandom & 32'hFFFF_FFFC;
            bus.BranchEX      = ($urandom_range(0, 5) == 0);
            bus.BranchTarget  = $urandom & 32'hFFFF_FFFC;
            if (i == 150) rst_n = 0;
            if (i == 152) rst_n = 1;
        end
        step(); clr();
        step();
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
